// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I execute stage: widths, ALU op codes,
// forwarding selects and branch funct3 codes.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_SLL  = 3'b110,
        ALU_SLTU = 3'b111
    } alu_op_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/execute_cycle_alu_core.sv
// Purely combinational integer ALU of the execute stage; results wrap mod 2^XLEN.
module alu_core
    import riscv_pkg::*;
#(
    parameter int XLEN_P = riscv_pkg::XLEN
) (
    input  logic [XLEN_P-1:0] src_a,
    input  logic [XLEN_P-1:0] src_b,
    input  logic [2:0]        alu_control,
    output logic [XLEN_P-1:0] result
);

    logic signed [XLEN_P-1:0] src_a_s;
    logic signed [XLEN_P-1:0] src_b_s;

    assign src_a_s = src_a;
    assign src_b_s = src_b;

    always_comb begin
        result = '0;
        case (alu_op_e'(alu_control))
            ALU_ADD:  result = src_a + src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_AND:  result = src_a & src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_XOR:  result = src_a ^ src_b;
            ALU_SLT:  result = {{(XLEN_P-1){1'b0}}, (src_a_s < src_b_s)};
            ALU_SLL:  result = src_a << src_b[4:0];
            ALU_SLTU: result = {{(XLEN_P-1){1'b0}}, (src_a < src_b)};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/execute_cycle.sv
// RV32I EX stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Optional build macro EX_MUL_EN adds a MUL low-word op on ALU code 110.
module execute_cycle
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              ResultSrcE,
    input  logic              MemWriteE,
    input  logic              JumpE,
    input  logic              BranchE,
    input  logic [2:0]        BranchOpE,
    input  logic [2:0]        ALUControlE,
    input  logic              ALUSrcE,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              FlushE,
    input  logic              EnM,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              RegWriteM,
    output logic              ResultSrcM,
    output logic              MemWriteM,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [REG_AW-1:0] RdM
);
    import riscv_pkg::*;

    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   write_d;
    logic [XLEN-1:0]   src_b;
    logic [XLEN-1:0]   core_result;
    logic [XLEN-1:0]   alu_result;
    logic signed [XLEN-1:0] cmp_a_s;
    logic signed [XLEN-1:0] cmp_b_s;
    logic              branch_cond;

    logic              reg_write_d,  reg_write_q;
    logic              result_src_d, result_src_q;
    logic              mem_write_d,  mem_write_q;
    logic [XLEN-1:0]   alu_result_d, alu_result_q;
    logic [XLEN-1:0]   write_data_d, write_data_q;
    logic [XLEN-1:0]   pc_plus4_d,   pc_plus4_q;
    logic [REG_AW-1:0] rd_d,         rd_q;

    // Code 11 falls back to the register-file value, same as 00.
    always_comb begin
        case (ForwardAE)
            FWD_W:   src_a = ResultW;
            FWD_M:   src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
        case (ForwardBE)
            FWD_W:   write_d = ResultW;
            FWD_M:   write_d = alu_result_q;
            default: write_d = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : write_d;

    alu_core #(.XLEN_P(XLEN)) u_alu_core (
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (ALUControlE),
        .result      (core_result)
    );

`ifdef EX_MUL_EN
    logic mul_sel;
    logic [XLEN-1:0] mul_lo;

    assign mul_sel    = (ALUControlE == ALU_SLL) && !ALUSrcE && BranchOpE[0];
    assign mul_lo     = src_a * src_b;
    assign alu_result = mul_sel ? mul_lo : core_result;
`else
    assign alu_result = core_result;
`endif

    assign cmp_a_s = src_a;
    assign cmp_b_s = write_d;

    always_comb begin
        case (BranchOpE)
            BR_BEQ:  branch_cond = (src_a == write_d);
            BR_BNE:  branch_cond = (src_a != write_d);
            BR_BLT:  branch_cond = (cmp_a_s < cmp_b_s);
            BR_BGE:  branch_cond = (cmp_a_s >= cmp_b_s);
            BR_BLTU: branch_cond = (src_a < write_d);
            BR_BGEU: branch_cond = (src_a >= write_d);
            default: branch_cond = 1'b0;
        endcase
    end

    // Redirect is combinational and deliberately not gated by FlushE.
    assign PCSrcE    = JumpE | (BranchE & branch_cond);
    assign PCTargetE = PCE + Imm_Ext_E;

    // EX/MEM boundary: flush beats hold, hold beats load.
    always_comb begin
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        mem_write_d  = mem_write_q;
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        pc_plus4_d   = pc_plus4_q;
        rd_d         = rd_q;
        if (FlushE) begin
            reg_write_d  = 1'b0;
            result_src_d = 1'b0;
            mem_write_d  = 1'b0;
            alu_result_d = '0;
            write_data_d = '0;
            pc_plus4_d   = '0;
            rd_d         = '0;
        end else if (EnM) begin
            reg_write_d  = RegWriteE;
            result_src_d = ResultSrcE;
            mem_write_d  = MemWriteE;
            alu_result_d = alu_result;
            write_data_d = write_d;
            pc_plus4_d   = PCPlus4E;
            rd_d         = RdE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            mem_write_q  <= mem_write_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign ResultSrcM = result_src_q;
    assign MemWriteM  = mem_write_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RdM        = rd_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed scenarios plus randomized
// traffic checked against a behavioural model of the EX stage.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [2:0]  BranchOpE, ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        FlushE, EnM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, ResultSrcM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;

    int checks = 0;
    int errors = 0;

    // expected EX/MEM contents
    logic        m_rw, m_rs, m_mw;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wd, m_pc4;

    logic [103:0] dut_m;
    assign dut_m = {RegWriteM, ResultSrcM, MemWriteM, RdM, ALUResultM, WriteDataM, PCPlus4M};

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .BranchOpE(BranchOpE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .FlushE(FlushE), .EnM(EnM),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM)
    );

    function automatic logic [103:0] exp_m();
        return {m_rw, m_rs, m_mw, m_rd, m_alu, m_wd, m_pc4};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a; sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a << b[4:0];
            default: return (a < b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a; sb = b;
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return sa < sb;
            3'b101: return sa >= sb;
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b01) return ResultW;
        if (sel == 2'b10) return m_alu;
        return rf;
    endfunction

    function automatic logic ref_pcsrc();
        return JumpE | (BranchE & ref_cond(BranchOpE, ref_fwd(ForwardAE, RD1_E), ref_fwd(ForwardBE, RD2_E)));
    endfunction

    function automatic logic [31:0] ref_target();
        return PCE + Imm_Ext_E;
    endfunction

    task automatic clear_inputs();
        RegWriteE = 0; ResultSrcE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0;
        BranchOpE = 0; ALUControlE = 0; ALUSrcE = 0;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
        RdE = 0; ForwardAE = 0; ForwardBE = 0; FlushE = 0; EnM = 1;
    endtask

    task automatic model_zero();
        m_rw = 0; m_rs = 0; m_mw = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
    endtask

    // One clock edge: model the register update from the pre-edge inputs.
    task automatic step();
        logic [31:0] a, wd, b, res;
        a   = ref_fwd(ForwardAE, RD1_E);
        wd  = ref_fwd(ForwardBE, RD2_E);
        b   = ALUSrcE ? Imm_Ext_E : wd;
        res = ref_alu(ALUControlE, a, b);
        @(posedge clk);
        if (!rst || FlushE) model_zero();
        else if (EnM) begin
            m_rw = RegWriteE; m_rs = ResultSrcE; m_mw = MemWriteE; m_rd = RdE;
            m_alu = res; m_wd = wd; m_pc4 = PCPlus4E;
        end
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        model_zero();
        PCE = 32'h40; Imm_Ext_E = 32'h8; JumpE = 1; RegWriteE = 1; RdE = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_m !== 104'd0) begin
            errors++; $display("FAIL reset_m actual=%h required=0", dut_m);
        end
        checks++;
        if (PCTargetE !== 32'h48 || PCSrcE !== 1'b1) begin
            errors++; $display("FAIL reset_redirect actual=%b/%h required=1/00000048", PCSrcE, PCTargetE);
        end
        @(negedge clk);
        rst = 1;
        clear_inputs();
    endtask

    task automatic test_add();
        @(negedge clk);
        clear_inputs();
        RD1_E = 5; RD2_E = 7; ALUControlE = 3'b000; RegWriteE = 1; RdE = 5'd4; PCPlus4E = 32'h14;
        step();
        checks++;
        if (ALUResultM !== 32'd12 || WriteDataM !== 32'd7) begin
            errors++; $display("FAIL add actual=%0d/%0d required=12/7", ALUResultM, WriteDataM);
        end
        checks++;
        if (dut_m !== exp_m()) begin
            errors++; $display("FAIL add_bundle actual=%h required=%h", dut_m, exp_m());
        end
    endtask

    task automatic test_wrap_slt();
        logic [31:0] req [3];
        logic [2:0]  ops [3];
        logic [31:0] a [3];
        logic [31:0] b [3];
        ops = '{3'b001, 3'b101, 3'b111};
        a   = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        b   = '{32'd1, 32'd1, 32'd1};
        req = '{32'hFFFFFFFF, 32'd1, 32'd0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_inputs();
            ALUControlE = ops[i]; RD1_E = a[i]; RD2_E = b[i];
            step();
            checks++;
            if (ALUResultM !== req[i]) begin
                errors++; $display("FAIL wrap_slt[%0d] actual=%h required=%h", i, ALUResultM, req[i]);
            end
        end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        clear_inputs();
        RD1_E = 32'h20;
        step();
        @(negedge clk);
        clear_inputs();
        ForwardAE = 2'b10; Imm_Ext_E = 4; ALUSrcE = 1; RD1_E = 32'h999;
        ForwardBE = 2'b01; ResultW = 32'hAB; RD2_E = 32'h55;
        step();
        checks++;
        if (ALUResultM !== 32'h24) begin
            errors++; $display("FAIL fwd_m actual=%h required=00000024", ALUResultM);
        end
        checks++;
        if (WriteDataM !== 32'hAB) begin
            errors++; $display("FAIL fwd_w actual=%h required=000000ab", WriteDataM);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        clear_inputs();
        BranchE = 1; BranchOpE = 3'b000; RD1_E = 3; RD2_E = 3; PCE = 32'h100; Imm_Ext_E = 32'h10;
        #1;
        checks++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h110) begin
            errors++; $display("FAIL beq actual=%b/%h required=1/00000110", PCSrcE, PCTargetE);
        end
        BranchOpE = 3'b001;
        #1;
        checks++;
        if (PCSrcE !== 1'b0) begin
            errors++; $display("FAIL bne actual=%b required=0", PCSrcE);
        end
        FlushE = 1; BranchOpE = 3'b000;
        #1;
        checks++;
        if (PCSrcE !== 1'b1) begin
            errors++; $display("FAIL beq_flush actual=%b required=1", PCSrcE);
        end
        step();
    endtask

    task automatic test_flush_hold();
        logic [103:0] held;
        @(negedge clk);
        clear_inputs();
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RdE = 5'd9; RD1_E = 1; RD2_E = 2; PCPlus4E = 32'h44;
        step();
        @(negedge clk);
        FlushE = 1; EnM = 0;
        step();
        checks++;
        if (RegWriteM !== 1'b0 || RdM !== 5'd0 || dut_m !== 104'd0) begin
            errors++; $display("FAIL flush_over_hold actual=%h required=0", dut_m);
        end
        @(negedge clk);
        FlushE = 0; EnM = 1; RdE = 5'd17; RD1_E = 32'h1234; PCPlus4E = 32'h88;
        step();
        held = exp_m();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            EnM = 0; RdE = 5'(i + 1); RD1_E = $urandom; RD2_E = $urandom; RegWriteE = ~RegWriteE;
            step();
            checks++;
            if (dut_m !== held) begin
                errors++; $display("FAIL hold[%0d] actual=%h required=%h", i, dut_m, held);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        clear_inputs();
        RegWriteE = 1; RdE = 5'd12; RD1_E = 32'h77; PCPlus4E = 32'h200;
        step();
        @(negedge clk);
        #2;
        rst = 0;
        model_zero();
        #1;
        checks++;
        if (dut_m !== 104'd0) begin
            errors++; $display("FAIL reset_async actual=%h required=0", dut_m);
        end
        RegWriteE = 1; RdE = 5'd21; RD1_E = 32'h30; RD2_E = 32'h6; ALUControlE = 3'b001; PCPlus4E = 32'h304;
        #1;
        rst = 1;
        step();
        checks++;
        if (RegWriteM !== 1'b1 || RdM !== 5'd21 || ALUResultM !== 32'h2A || PCPlus4M !== 32'h304) begin
            errors++; $display("FAIL reset_release actual=%b/%0d/%h/%h required=1/21/0000002a/00000304",
                               RegWriteM, RdM, ALUResultM, PCPlus4M);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            RegWriteE = $urandom; ResultSrcE = $urandom; MemWriteE = $urandom;
            JumpE = ($urandom_range(0, 5) == 0); BranchE = $urandom;
            BranchOpE = $urandom; ALUControlE = $urandom; ALUSrcE = $urandom;
            RD1_E = ($urandom_range(0, 3) == 0) ? RD2_E : $urandom;
            RD2_E = $urandom; Imm_Ext_E = $urandom; PCE = $urandom; PCPlus4E = $urandom;
            ResultW = $urandom; RdE = $urandom; ForwardAE = $urandom; ForwardBE = $urandom;
            FlushE = ($urandom_range(0, 7) == 0); EnM = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (PCSrcE !== ref_pcsrc() || PCTargetE !== ref_target()) begin
                errors++; $display("FAIL rand_redirect[%0d] actual=%b/%h required=%b/%h",
                                   i, PCSrcE, PCTargetE, ref_pcsrc(), ref_target());
            end
            step();
            checks++;
            if (dut_m !== exp_m()) begin
                errors++; $display("FAIL rand_m[%0d] actual=%h required=%h", i, dut_m, exp_m());
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap_slt();
        test_forwarding();
        test_branch();
        test_flush_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
